// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
//
// Collects two 4-bit operands and an add/subtract select from slide switches,
// one push-button press at a time, and hands them to a downstream add/sub
// stage as a complete operation with a one-cycle OP_VALID strobe.
//
// Sequence: WAIT_A --press--> WAIT_B --press--> HOLD --press--> WAIT_B ...
//   WAIT_A/HOLD press : OP_A <= SW[3:0], OP_B <= 0
//   WAIT_B press      : OP_B <= SW[3:0], OP_SUB <= SW[4], pulse OP_VALID
//
// Ports
//   MAX10_CLK1_50  in   system clock, all state on its rising edge
//   RESET_N        in   asynchronous active-low reset
//   KEY1           in   enter push-button, active-low, asynchronous
//   SW[4:0]        in   SW[3:0] operand, SW[4] op select (1 = subtract)
//   OP_A[3:0]      out  captured operand A
//   OP_B[3:0]      out  captured operand B
//   OP_SUB         out  captured op select (1 = A-B)
//   OP_VALID       out  one-cycle strobe, new complete operation
//   STATE_LED[1:0] out  01 = awaiting A, 10 = awaiting B, 00 = result held
//
// Build option
//   OPERAND_SEQUENCER_DEBOUNCE_EN : when defined, the synchronized key must be
//   stable for DEBOUNCE_CYCLES consecutive samples before the conditioned key
//   follows it. When undefined, the conditioned key is the synchronizer output
//   and DEBOUNCE_CYCLES has no effect.
//
// Press-to-capture latency (no debounce): key low at rising edge k, capture
// and OP_VALID visible after edge k+3 (2 sync flops + registered press event).
// ---------------------------------------------------------------------------
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET_N,
    input  logic       KEY1,
    input  logic [4:0] SW,
    output logic [3:0] OP_A,
    output logic [3:0] OP_B,
    output logic       OP_SUB,
    output logic       OP_VALID,
    output logic [1:0] STATE_LED
);

    // State encodings double as the LED pattern.
    localparam logic [1:0] WAIT_A = 2'b01;
    localparam logic [1:0] WAIT_B = 2'b10;
    localparam logic [1:0] HOLD   = 2'b00;

    // -----------------------------------------------------------------------
    // Key synchronizer (resets to released)
    // -----------------------------------------------------------------------
    logic sync1_q, sync2_q;

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= KEY1;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Key conditioning
    // -----------------------------------------------------------------------
    logic key_cond;

`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_cond_q, key_cond_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the conditioned
    // level; a sample that agrees breaks the run and restarts it at 0. The
    // level flips on the DEBOUNCE_CYCLES-th disagreeing sample. The counter
    // stops at CNT_LAST so it can never wrap.
    always_comb begin
        key_cond_d = key_cond_q;
        cnt_d      = cnt_q;
        if (sync2_q == key_cond_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            key_cond_d = sync2_q;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_cond_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            key_cond_q <= key_cond_d;
            cnt_q      <= cnt_d;
        end
    end

    assign key_cond = key_cond_q;
`else
    assign key_cond = sync2_q;
`endif

    // -----------------------------------------------------------------------
    // Press detection
    //
    // The synchronizer resets to "released", so a key already held across
    // reset would otherwise look like a fresh falling edge. arm_q only sets
    // once a genuinely sampled high has reached sync2_q (fill_q tracks when
    // both flops hold real samples), so that held key needs a release first.
    // -----------------------------------------------------------------------
    logic [1:0] fill_q;
    logic       arm_q;
    logic       key_prev_q;
    logic       press_q;
    logic       press_d;

    assign press_d = arm_q & key_prev_q & ~key_cond;

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            fill_q     <= 2'b00;
            arm_q      <= 1'b0;
            key_prev_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            fill_q     <= {fill_q[0], 1'b1};
            arm_q      <= arm_q | (fill_q[1] & sync2_q);
            key_prev_q <= key_cond;
            press_q    <= press_d;
        end
    end

    // -----------------------------------------------------------------------
    // Operand FSM
    // -----------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic       op_sub_q, op_sub_d;
    logic       valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_sub_d = op_sub_q;
        valid_d  = 1'b0;
        if (press_q) begin
            case (state_q)
                WAIT_A, HOLD: begin
                    op_a_d  = SW[3:0];
                    op_b_d  = 4'h0;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    op_b_d   = SW[3:0];
                    op_sub_d = SW[4];
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end
                default: begin
                    state_d = WAIT_A;
                end
            endcase
        end else if (state_q == 2'b11) begin
            // Unreachable encoding: fall back to a clean start.
            state_d = WAIT_A;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= WAIT_A;
            op_a_q   <= 4'h0;
            op_b_q   <= 4'h0;
            op_sub_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_sub_q <= op_sub_d;
            valid_q  <= valid_d;
        end
    end

    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign OP_SUB    = op_sub_q;
    assign OP_VALID  = valid_q;
    assign STATE_LED = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_operand_sequencer
//
// Directed bench. Each press that should complete an operation pushes the
// expected operands and strobe cycle to a scoreboard; a negedge monitor pops
// and compares on every OP_VALID. Static outputs are checked after each step.
// Define OPERAND_SEQUENCER_DEBOUNCE_EN for both files to run the bounce step.
// ---------------------------------------------------------------------------
module tb_operand_sequencer;

    localparam int DBC = 4;
`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
    localparam int DB = DBC;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 4 + DB;  // negedge drive -> negedge after capture edge

    logic       clk = 1'b0;
    logic       RESET_N = 1'b0;
    logic       KEY1 = 1'b1;
    logic [4:0] SW = 5'h0;
    logic [3:0] OP_A, OP_B;
    logic       OP_SUB, OP_VALID;
    logic [1:0] STATE_LED;

    operand_sequencer #(.DEBOUNCE_CYCLES(DBC)) dut (
        .MAX10_CLK1_50 (clk),
        .RESET_N       (RESET_N),
        .KEY1          (KEY1),
        .SW            (SW),
        .OP_A          (OP_A),
        .OP_B          (OP_B),
        .OP_SUB        (OP_SUB),
        .OP_VALID      (OP_VALID),
        .STATE_LED     (STATE_LED)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (OP_VALID) begin
            checks++;
            assert (prev_v === 1'b0) else begin
                errors++;
                $error("FAIL valid_twice obs=1 exp=0 cyc=%0d", cyc);
            end
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_valid obs=A%0h B%0h S%0b exp=none cyc=%0d",
                       OP_A, OP_B, OP_SUB, cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert ({OP_A, OP_B, OP_SUB} === {e.a, e.b, e.sub} && cyc == e.cyc) else begin
                    errors++;
                    $error("FAIL op_valid obs=A%0h B%0h S%0b @%0d exp=A%0h B%0h S%0b @%0d",
                           OP_A, OP_B, OP_SUB, cyc, e.a, e.b, e.sub, e.cyc);
                end
            end
        end
        prev_v = OP_VALID;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic s, input logic [1:0] led);
        chk({tag, "_a"},   {4'h0, OP_A}, {4'h0, a});
        chk({tag, "_b"},   {4'h0, OP_B}, {4'h0, b});
        chk({tag, "_sub"}, {7'h0, OP_SUB}, {7'h0, s});
        chk({tag, "_led"}, {6'h0, STATE_LED}, {6'h0, led});
    endtask

    // Press at a negedge, hold for `hold` cycles, release and let it settle.
    task automatic press(input logic [4:0] sw, input int hold, input bit exp_v,
                         input logic [3:0] ea, input logic [3:0] eb, input logic es);
        exp_t e;
        @(negedge clk);
        SW   = sw;
        KEY1 = 1'b0;
        if (exp_v) begin
            e.a = ea; e.b = eb; e.sub = es; e.cyc = cyc + LAT;
            sb.push_back(e);
        end
        repeat (hold) @(negedge clk);
        KEY1 = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_outs("rst", 4'h0, 4'h0, 1'b0, 2'b01);
        chk("rst_valid", {7'h0, OP_VALID}, 8'h0);
        RESET_N = 1'b1;
        repeat (5) @(negedge clk);

        // Basic add operation
        press(5'b0_0110, 10, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_outs("capA", 4'h6, 4'h0, 1'b0, 2'b10);
        press(5'b0_0001, 10, 1'b1, 4'h6, 4'h1, 1'b0);
        chk_outs("add", 4'h6, 4'h1, 1'b0, 2'b00);

        // Switch changes with no press must not disturb anything
        SW = 5'h1F;
        repeat (6) @(negedge clk);
        chk_outs("sw_idle", 4'h6, 4'h1, 1'b0, 2'b00);

        // New A from HOLD: B cleared, SUB kept, no strobe
        press(5'b0_1111, 10, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_outs("holdA", 4'hF, 4'h0, 1'b0, 2'b10);

        // Subtract with the key held for 20 cycles
        press(5'b1_1000, 20, 1'b1, 4'hF, 4'h8, 1'b1);
        chk_outs("sub", 4'hF, 4'h8, 1'b1, 2'b00);

        // A=0110 then subtract 1000; SUB stays 1 while waiting for B
        press(5'b0_0110, 10, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_outs("A6", 4'h6, 4'h0, 1'b1, 2'b10);
        press(5'b1_1000, 20, 1'b1, 4'h6, 4'h8, 1'b1);
        chk_outs("sub2", 4'h6, 4'h8, 1'b1, 2'b00);

        // Mid-operation async reset with key held through it
        press(5'b0_0110, 10, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_outs("preRst", 4'h6, 4'h0, 1'b1, 2'b10);
        @(negedge clk);
        #2;
        KEY1    = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk_outs("midRst", 4'h0, 4'h0, 1'b0, 2'b01);
        chk("midRst_valid", {7'h0, OP_VALID}, 8'h0);
        @(posedge clk);
        @(negedge clk);
        RESET_N = 1'b1;
        repeat (12) @(negedge clk);
        chk_outs("heldKey", 4'h0, 4'h0, 1'b0, 2'b01);
        KEY1 = 1'b1;
        repeat (12) @(negedge clk);
        press(5'b0_0011, 10, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_outs("repress", 4'h3, 4'h0, 1'b0, 2'b10);
        press(5'b0_0100, 10, 1'b1, 4'h3, 4'h4, 1'b0);
        chk_outs("postRst", 4'h3, 4'h4, 1'b0, 2'b00);

`ifdef OPERAND_SEQUENCER_DEBOUNCE_EN
        // Bouncing key: only the final stable low counts
        press(5'b0_0010, 10, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_outs("dbA", 4'h2, 4'h0, 1'b0, 2'b10);
        SW = 5'b1_0101;
        for (int i = 0; i < 3; i++) begin
            KEY1 = 1'b0;
            repeat (2) @(negedge clk);
            KEY1 = 1'b1;
            repeat (2) @(negedge clk);
        end
        chk_outs("bounce", 4'h2, 4'h0, 1'b0, 2'b10);
        press(5'b1_0101, 10, 1'b1, 4'h2, 4'h5, 1'b1);
        chk_outs("dbB", 4'h2, 4'h5, 1'b1, 2'b00);
`endif

        repeat (10) @(negedge clk);
        chk("sb_empty", 8'(sb.size()), 8'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
